mips_mc_ctrl_fsm: RTL and testbench
===================================

Name: mips_mc_ctrl_fsm

Overview:
- Main control state machine of the multi-cycle, non-pipelined MIPS core.
- Sits directly upstream of the datapath state registers: PC, IR, MDR, A/B, ALUOut and the register file. It generates their per-cycle write enables and the datapath mux selects.
- Decodes the opcode held in IR and sequences one instruction through 3-5 cycles.
- Stalls on a memory ready handshake.

Parameters:
- OP_W, 6, opcode width.
- STATE_W, 4, width of the state_dbg output.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag; valid in the BEQEX cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write  out  1  IR enable.
- pc_en  out  1  PC enable; equals pc_write | (branch & zero).
- reg_write  out  1  register file write enable.
- mem_write  out  1  memory write request.
- mem_read  out  1  memory read request.
- iord  out  1  0 selects PC as memory address; 1 selects ALUOut.
- mem_to_reg  out  1  1 selects MDR as write-back data; 0 selects ALUOut.
- reg_dst  out  1  1 selects rd; 0 selects rt.
- alu_src_a  out  1  0 selects PC; 1 selects A.
- alu_src_b  out  2  00 B; 01 constant 4; 10 sign-extended immediate; 11 sign-extended immediate << 2.
- alu_op  out  2  00 add; 01 sub; 10 funct decode.
- pc_src  out  2  00 ALU result; 01 ALUOut; 10 jump target.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Reset: on a clk edge with rst=1, state goes to FETCH and illegal_op clears. While rst=1, every output listed below is forced to 0:
  - enables: ir_write, pc_en, reg_write, mem_write, mem_read;
  - selects: iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src.
- Reset applies mid-instruction: any state returns to FETCH with no write enable asserted in the reset cycle.
- Outputs are Moore (decoded from state only), except:
  - the pc_en zero term;
  - mem_ready gating, as listed below.
- Any output not listed for a state is 0.
- State encodings and outputs:
  - FETCH=0: mem_read=1, alu_src_b=01. ir_write and pc_write are asserted only when mem_ready=1.
  - DECODE=1: alu_src_b=11.
  - MEMADR=2: alu_src_a=1, alu_src_b=10.
  - MEMRD=3: mem_read=1, iord=1.
  - MEMWB=4: reg_write=1, mem_to_reg=1.
  - MEMWR=5: mem_write=1, iord=1.
  - RTYPEEX=6: alu_src_a=1, alu_op=10.
  - ALUWB=7: reg_write=1, reg_dst=1.
  - BEQEX=8: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
  - ADDIEX=9: alu_src_a=1, alu_src_b=10.
  - ADDIWB=10: reg_write=1.
  - JEX=11: pc_src=10, pc_write=1.
- Transitions:
  - FETCH -> DECODE when mem_ready=1; otherwise hold in FETCH.
  - DECODE dispatches on opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> RTYPEEX.
    - 000100 (beq) -> BEQEX.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JEX.
    - any other opcode -> FETCH, with illegal_op=1 for exactly the next cycle.
  - MEMADR -> MEMRD for lw, -> MEMWR for sw. Opcode is stable from IR.
  - MEMRD -> MEMWB when mem_ready=1; otherwise hold.
  - MEMWR -> FETCH when mem_ready=1; otherwise hold, keeping mem_write and iord asserted.
  - MEMWB, ALUWB, ADDIWB, BEQEX and JEX -> FETCH.
  - RTYPEEX -> ALUWB.
  - ADDIEX -> ADDIWB.
  - Encodings 12-15 are unreachable; if entered, go to FETCH.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Write enables never assert in a cycle in which the FSM is holding for mem_ready, except the mem_write request itself.
- At most one of ir_write, reg_write and mem_write is high in any cycle.

Test Plan:
- Reset: assert rst for 2 cycles from MEMWR, then release with mem_ready=1 -> all enables 0 during reset; state_dbg=0 the cycle after release; ir_write=1 and pc_en=1 in that cycle.
- lw sequence: opcode=100011, mem_ready=1 -> state_dbg 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- sw with wait states: opcode=101011, mem_ready held low for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, then FETCH. Total 7 cycles.
- beq taken vs not taken: opcode=000100 -> with zero=1, pc_en=1 and pc_src=01 in BEQEX; with zero=0, pc_en=0. Both cases return to FETCH after 3 cycles.
- Illegal opcode: opcode=111111 in DECODE -> next state FETCH; illegal_op=1 for one cycle; no reg_write or mem_write at any point.
- R-type, addi, j back to back with mem_ready=1 -> state sequences:
  - R-type: 0,1,6,7.
  - addi: 0,1,9,10.
  - j: 0,1,11, with pc_en=1 and pc_src=10 in state 11.
  - reg_dst=1 only in ALUWB.

Source files
------------

// File: rtl/mips_mc_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle MIPS control FSM and its datapath.
// The FSM uses the slave view; the datapath (or a bench) uses the master view.
interface mips_mc_ctrl_fsm_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
);
  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               mem_ready;
  logic               ir_write;
  logic               pc_en;
  logic               reg_write;
  logic               mem_write;
  logic               mem_read;
  logic               iord;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    output opcode, zero, mem_ready,
    input  ir_write, pc_en, reg_write, mem_write, mem_read, iord, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state_dbg
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output ir_write, pc_en, reg_write, mem_write, mem_read, iord, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/
// write-back and drives datapath enables and mux selects from the current state.
module mips_mc_ctrl_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  mips_mc_ctrl_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctl_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  state_t r_state;
  state_t w_state_next;
  logic   w_illegal_next;
  logic   r_illegal;
  ctl_t   r_ctl;
  logic   w_run;

  // Moore control word for a state; unreachable encodings decode to all-zero.
  function automatic ctl_t ctl_decode(input state_t st);
    ctl_t c;
    c = '0;
    case (st)
      FETCH:   begin c.fetch = 1'b1; c.pc_write = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:  c.alu_src_b = 2'b11;
      MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      RTYPEEX: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BEQEX:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB:  c.reg_write = 1'b1;
      JEX:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_state_next   = r_state;
    w_illegal_next = 1'b0;
    case (r_state)
      FETCH:   if (bus.mem_ready) w_state_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_state_next = MEMADR;
          OP_RTYPE:     w_state_next = RTYPEEX;
          OP_BEQ:       w_state_next = BEQEX;
          OP_ADDI:      w_state_next = ADDIEX;
          OP_J:         w_state_next = JEX;
          default: begin
            w_state_next   = FETCH;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      MEMADR:  w_state_next = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (bus.mem_ready) w_state_next = MEMWB;
      MEMWR:   if (bus.mem_ready) w_state_next = FETCH;
      RTYPEEX: w_state_next = ALUWB;
      ADDIEX:  w_state_next = ADDIWB;
      default: w_state_next = FETCH;
    endcase
  end

  // The control word is registered from the next state so it lines up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_ctl     <= ctl_decode(FETCH);
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_illegal_next;
      r_ctl     <= ctl_decode(w_state_next);
    end
  end

  assign w_run = ~rst;

  // FETCH only commits IR/PC on the cycle memory actually returns the word.
  assign bus.ir_write   = w_run & r_ctl.fetch & bus.mem_ready;
  assign bus.pc_en      = w_run & ((r_ctl.pc_write & (~r_ctl.fetch | bus.mem_ready))
                                   | (r_ctl.branch & bus.zero));
  assign bus.reg_write  = w_run & r_ctl.reg_write;
  assign bus.mem_write  = w_run & r_ctl.mem_write;
  assign bus.mem_read   = w_run & r_ctl.mem_read;
  assign bus.iord       = w_run & r_ctl.iord;
  assign bus.mem_to_reg = w_run & r_ctl.mem_to_reg;
  assign bus.reg_dst    = w_run & r_ctl.reg_dst;
  assign bus.alu_src_a  = w_run & r_ctl.alu_src_a;
  assign bus.alu_src_b  = {2{w_run}} & r_ctl.alu_src_b;
  assign bus.alu_op     = {2{w_run}} & r_ctl.alu_op;
  assign bus.pc_src     = {2{w_run}} & r_ctl.pc_src;
  assign bus.illegal_op = r_illegal;
  assign bus.state_dbg  = STATE_W'(r_state);
endmodule

// File: tb/tb_mips_mc_ctrl_fsm.sv
// Self-checking bench for mips_mc_ctrl_fsm: per-cycle expected control words are
// queued as stimulus is applied and compared against the DUT at the falling edge.
module tb_mips_mc_ctrl_fsm;
  logic clk;
  logic rst;

  mips_mc_ctrl_fsm_if #(.OP_W(6), .STATE_W(4)) bus ();

  mips_mc_ctrl_fsm #(.OP_W(6), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       il;
    logic       ir;
    logic       pe;
    logic       rw;
    logic       mw;
    logic       mr;
    logic       iord;
    logic       m2r;
    logic       rd;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] psrc;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Expected outputs for one cycle, straight from the state/output table.
  function automatic exp_t mk(int st, bit mrdy, bit z, bit rs, bit il);
    exp_t e;
    e    = '0;
    e.st = st[3:0];
    e.il = il;
    if (!rs) begin
      case (st)
        0:  begin e.mr = 1; e.asb = 2'b01; e.ir = mrdy; e.pe = mrdy; end
        1:  e.asb = 2'b11;
        2:  begin e.asa = 1; e.asb = 2'b10; end
        3:  begin e.mr = 1; e.iord = 1; end
        4:  begin e.rw = 1; e.m2r = 1; end
        5:  begin e.mw = 1; e.iord = 1; end
        6:  begin e.asa = 1; e.aop = 2'b10; end
        7:  begin e.rw = 1; e.rd = 1; end
        8:  begin e.asa = 1; e.aop = 2'b01; e.psrc = 2'b01; e.pe = z; end
        9:  begin e.asa = 1; e.asb = 2'b10; end
        10: e.rw = 1;
        11: begin e.psrc = 2'b10; e.pe = 1; end
        default: e = e;
      endcase
    end
    return e;
  endfunction

  task automatic cyc(input int st, input bit mrdy, input bit z, input bit rs,
                     input bit il, input string tag);
    exp_t e;
    exp_t o;
    bus.mem_ready = mrdy;
    bus.zero      = z;
    rst           = rs;
    sb.push_back(mk(st, mrdy, z, rs, il));
    @(negedge clk);
    o = {bus.state_dbg, bus.illegal_op, bus.ir_write, bus.pc_en, bus.reg_write,
         bus.mem_write, bus.mem_read, bus.iord, bus.mem_to_reg, bus.reg_dst,
         bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src};
    e = sb.pop_front();
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got state=%0d word=%h, expected state=%0d word=%h",
               tag, o.st, o, e.st, e);
    end else begin
      $display("[TB] %s ok: state=%0d word=%h", tag, o.st, o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.opcode = 6'b101011;
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_hold");
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_decode");
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, "rst_memadr");
    cyc(5, 1'b0, 1'b0, 1'b1, 1'b0, "rst_in_memwr");
    cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, "rst_second");
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_release");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_sw_decode");
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, "rst_sw_memadr");
    cyc(5, 1'b1, 1'b0, 1'b0, 1'b0, "rst_sw_memwr");
  endtask

  task automatic test_lw();
    bus.opcode = 6'b100011;
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "lw_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "lw_decode");
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, "lw_memadr");
    cyc(3, 1'b1, 1'b0, 1'b0, 1'b0, "lw_memrd");
    cyc(4, 1'b1, 1'b0, 1'b0, 1'b0, "lw_memwb");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, "lww_fetch_wait");
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "lww_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "lww_decode");
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, "lww_memadr");
    cyc(3, 1'b0, 1'b0, 1'b0, 1'b0, "lww_memrd_wait");
    cyc(3, 1'b1, 1'b0, 1'b0, 1'b0, "lww_memrd");
    cyc(4, 1'b1, 1'b0, 1'b0, 1'b0, "lww_memwb");
  endtask

  task automatic test_sw_wait();
    bus.opcode = 6'b101011;
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "sw_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "sw_decode");
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0, "sw_memadr");
    for (int i = 0; i < 3; i++)
      cyc(5, 1'b0, 1'b0, 1'b0, 1'b0, "sw_memwr_wait");
    cyc(5, 1'b1, 1'b0, 1'b0, 1'b0, "sw_memwr_done");
  endtask

  task automatic test_beq();
    bus.opcode = 6'b000100;
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "beqt_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "beqt_decode");
    cyc(8, 1'b1, 1'b1, 1'b0, 1'b0, "beqt_ex_taken");
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "beqn_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "beqn_decode");
    cyc(8, 1'b1, 1'b0, 1'b0, 1'b0, "beqn_ex_not_taken");
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b111111;
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "ill_fetch");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "ill_decode");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "ill_pulse");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, "ill_pulse_gone");
  endtask

  task automatic test_back_to_back();
    bus.opcode = 6'b000000;
    cyc(0,  1'b1, 1'b0, 1'b0, 1'b0, "r_fetch");
    cyc(1,  1'b1, 1'b0, 1'b0, 1'b0, "r_decode");
    cyc(6,  1'b1, 1'b1, 1'b0, 1'b0, "r_ex_zero_ignored");
    cyc(7,  1'b1, 1'b0, 1'b0, 1'b0, "r_aluwb");
    bus.opcode = 6'b001000;
    cyc(0,  1'b1, 1'b0, 1'b0, 1'b0, "addi_fetch");
    cyc(1,  1'b1, 1'b0, 1'b0, 1'b0, "addi_decode");
    cyc(9,  1'b1, 1'b0, 1'b0, 1'b0, "addi_ex");
    cyc(10, 1'b1, 1'b0, 1'b0, 1'b0, "addi_wb");
    bus.opcode = 6'b000010;
    cyc(0,  1'b1, 1'b0, 1'b0, 1'b0, "j_fetch");
    cyc(1,  1'b1, 1'b0, 1'b0, 1'b0, "j_decode");
    cyc(11, 1'b1, 1'b0, 1'b0, 1'b0, "j_ex");
    cyc(0,  1'b0, 1'b0, 1'b0, 1'b0, "j_back_to_fetch");
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
